rram_pulse_sequencer: RTL
=========================

# rram_pulse_sequencer

Digital controller that sequences one RRAM array operation (READ, SET or RESET) on the analog block's control pins behind the pad ring. It accepts a command over a valid/ready handshake and drives address, data, DAC enables and line enables with programmable setup and pulse widths. For reads it strobes the sense amps and captures `sa_do`, then returns a response. It also drives the `rram_busy` indicator.

## Interface
Parameters:
- `WORD_W`, 48, data word width; matches `sa_do`/`di`.
- `ADDR_W`, 16, array address width.
- `CNT_W`, 8, width of the setup, pulse and timeout counters.

Ports:
- `mclk`  in  1  system clock.
- `rst_n`  in  1  reset. Synchronous and active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_op`  in  2  operation: 00 READ, 01 SET, 10 RESET, 11 illegal.
- `cmd_addr`  in  ADDR_W  target address.
- `cmd_wdata`  in  WORD_W  write data mask for SET/RESET.
- `cfg_setup`  in  CNT_W  setup cycles before the pulse; 0 is treated as 1.
- `cfg_pw`  in  CNT_W  pulse-width cycles; 0 is treated as 1.
- `cfg_timeout`  in  CNT_W  maximum number of SENSE cycles to wait for `sa_rdy`.
- `rsp_valid`  out  1  response pending.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  WORD_W  captured `sa_do`; 0 for writes.
- `rsp_err`  out  2  error code: 00 ok, 01 sense timeout, 10 illegal op.
- `rram_addr`  out  ADDR_W  array address.
- `di`  out  WORD_W  write data.
- `we`  out  1  write enable.
- `set_rst`  out  1  1 = SET, 0 = RESET.
- `wl_dac_en`, `bsl_dac_en`, `read_dac_en`  out  1 each  DAC enables.
- `wl_en`, `bl_en`, `sl_en`  out  1 each  line enables.
- `sa_en`, `sa_clk`  out  1 each  sense-amp enable and strobe.
- `sa_do`  in  WORD_W  sense-amp data. Stable whenever synchronized `sa_rdy` is high.
- `sa_rdy`  in  1  asynchronous sense-amp ready.
- `rram_busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, SETUP, PULSE, SENSE, RECOVER, RESP.
- Reset behaviour: all outputs are registered and 0 after reset. The exception is `cmd_ready`, which is 1 because the state is IDLE.
- **IDLE**
  - On `cmd_valid & cmd_ready`, latch op, addr, wdata and the cfg values. The cfg inputs are sampled only at acceptance.
  - Legal op: go to SETUP. Op 11: go to RESP with `rsp_err`=10 and no pin activity.
- **SETUP** (lasts max(cfg_setup,1) cycles)
  - `rram_addr` is driven for the whole operation.
  - READ: `read_dac_en`=1 and `wl_dac_en`=1.
  - SET/RESET: `wl_dac_en`=1, `bsl_dac_en`=1, `we`=1, `di`=wdata, `set_rst`=(op==SET).
- **PULSE** (lasts max(cfg_pw,1) cycles)
  - DAC enables are held and `wl_en`=1.
  - READ: `bl_en`=1.
  - SET: `bl_en`=1.
  - RESET: `sl_en`=1.
  - On exit: READ goes to SENSE; writes go to RECOVER.
- **SENSE**
  - `sa_en`=1, `wl_en`=1 and `bl_en`=1 are held.
  - `sa_clk`=1 for exactly the first SENSE cycle.
  - `sa_rdy` passes through a 2-flop synchronizer.
  - When the synchronized value is 1, capture `sa_do` into `rsp_rdata` (err 00) and go to RECOVER.
  - If `cfg_timeout` cycles elapse first, set `rsp_err`=01, leave `rsp_rdata`=0 and go to RECOVER.
  - `cfg_timeout`=0 times out after 1 cycle.
- **RECOVER** (1 cycle)
  - All enables, `we`, `sa_en` and `sa_clk` are 0.
  - `rram_addr` and `di` are held.
  - Then go to RESP.
- **RESP**
  - `rsp_valid`=1 and the response fields are held stable.
  - On `rsp_ready`, go to IDLE, clear `rram_addr`/`di` to 0 and drop `rsp_valid`.
- Line enables (`wl_en`/`bl_en`/`sl_en`) are never asserted outside PULSE/SENSE. `bl_en` and `sl_en` are never high together.
- `rst_n` low in any state: next edge all outputs go to 0 and state goes to IDLE. No response is produced for the aborted command.

## Timing
- Command accepted at edge T0. SETUP outputs are visible after T0.
- PULSE begins after edge T0+S, where S=max(cfg_setup,1).
- Write `rsp_valid` rises after edge T0+S+P+1, where P=max(cfg_pw,1).
- Read latency adds SENSE cycles. The minimum is 3 SENSE cycles, because of the synchronizer plus the capture.
- `cmd_ready` is 0 from the cycle after acceptance until the cycle after `rsp_valid & rsp_ready`. No back-to-back acceptance is allowed; the minimum gap is 1 IDLE cycle.
- `sa_rdy` high on entry to SENSE is still synchronized; it is never sampled raw.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles -> all outputs 0, `cmd_ready`=1, `rram_busy`=0.
- **SET:** addr=0x0012, wdata=0xA5, setup=2, pw=3 -> `we`/`bsl_dac_en` for 5 cycles; `wl_en`/`bl_en` for 3 cycles only; `set_rst`=1; `sl_en` never set; `rsp_valid` 7 cycles after accept; err=00, rdata=0.
- **RESET:** pw=0 -> `sl_en` for exactly 1 cycle; `bl_en` never set; `set_rst`=0.
- **READ:** `sa_rdy` asserted 4 cycles into SENSE with `sa_do`=0xDEADBEEF -> `sa_clk` high 1 cycle; `rsp_rdata`=0xDEADBEEF; err=00.
- **Timeout and illegal op:** READ with timeout=5 and `sa_rdy` stuck 0 -> err=01 after 5 SENSE cycles. `cmd_op`=11 -> err=10 with no enable toggled.
- **Abort and backpressure:** `rst_n` low during PULSE -> `wl_en`=0 next edge, no `rsp_valid`. `rsp_ready` held 0 for 10 cycles -> response stable and `cmd_ready`=0 throughout.

Source files
------------

// File: rtl/rram_pulse_sequencer.sv
// rtl/rram_pulse_sequencer.sv - sequences one RRAM READ/SET/RESET on the analog control pins
// All pin outputs are registered copies of values decoded from the next state.
module rram_pulse_sequencer #(
  parameter int WORD_W = 48,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WORD_W-1:0] cmd_wdata,
  input  logic [CNT_W-1:0]  cfg_setup,
  input  logic [CNT_W-1:0]  cfg_pw,
  input  logic [CNT_W-1:0]  cfg_timeout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] rram_addr,
  output logic [WORD_W-1:0] di,
  output logic              we,
  output logic              set_rst,
  output logic              wl_dac_en,
  output logic              bsl_dac_en,
  output logic              read_dac_en,
  output logic              wl_en,
  output logic              bl_en,
  output logic              sl_en,
  output logic              sa_en,
  output logic              sa_clk,
  input  logic [WORD_W-1:0] sa_do,
  input  logic              sa_rdy,
  output logic              rram_busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_PULSE, ST_SENSE, ST_RECOVER, ST_RESP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  pw_q, pw_nxt;
  logic [CNT_W-1:0]  to_q, to_nxt;
  logic [1:0]        op_q, op_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [WORD_W-1:0] wdata_q, wdata_nxt;
  logic [WORD_W-1:0] rdata_nxt;
  logic [1:0]        err_nxt;
  logic              rdy_meta, rdy_sync;

  logic [ADDR_W-1:0] rram_addr_nxt;
  logic [WORD_W-1:0] di_nxt;
  logic we_nxt, set_rst_nxt, wl_dac_nxt, bsl_dac_nxt, read_dac_nxt;
  logic wl_en_nxt, bl_en_nxt, sl_en_nxt, sa_en_nxt, sa_clk_nxt;
  logic is_rd, is_wr, drive_phase;

  // Counters hold (cycles - 1); a programmed 0 behaves like 1.
  function automatic logic [CNT_W-1:0] cnt_load(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_ONE;
  endfunction

  // Synchronizer is flushed outside SENSE so a stale ready can never shortcut the capture.
  always_ff @(posedge mclk) begin
    if (!rst_n || state != ST_SENSE) begin
      rdy_meta <= 1'b0;
      rdy_sync <= 1'b0;
    end else begin
      rdy_meta <= sa_rdy;
      rdy_sync <= rdy_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pw_nxt    = pw_q;
    to_nxt    = to_q;
    op_nxt    = op_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    rdata_nxt = rsp_rdata;
    err_nxt   = rsp_err;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_nxt    = cmd_op;
          addr_nxt  = cmd_addr;
          wdata_nxt = cmd_wdata;
          pw_nxt    = cfg_pw;
          to_nxt    = cfg_timeout;
          rdata_nxt = '0;
          if (cmd_op == OP_ILL) begin
            err_nxt   = ERR_ILLEGAL;
            state_nxt = ST_RESP;
          end else begin
            err_nxt   = ERR_OK;
            cnt_nxt   = cnt_load(cfg_setup);
            state_nxt = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          cnt_nxt   = cnt_load(pw_q);
          state_nxt = ST_PULSE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          if (op_q == OP_READ) begin
            cnt_nxt   = cnt_load(to_q);
            state_nxt = ST_SENSE;
          end else begin
            state_nxt = ST_RECOVER;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_SENSE: begin
        if (rdy_sync) begin
          rdata_nxt = sa_do;
          state_nxt = ST_RECOVER;
        end else if (cnt == '0) begin
          err_nxt   = ERR_TIMEOUT;
          state_nxt = ST_RECOVER;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_RECOVER: state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pin decode from the upcoming state so every pin is a plain flop.
  always_comb begin
    is_rd       = (op_nxt == OP_READ);
    is_wr       = (op_nxt == OP_SET) || (op_nxt == OP_RESET);
    drive_phase = (state_nxt == ST_SETUP) || (state_nxt == ST_PULSE);
    rram_addr_nxt = '0;
    di_nxt        = '0;
    if (state_nxt != ST_IDLE && op_nxt != OP_ILL) begin
      rram_addr_nxt = addr_nxt;
      if (is_wr) di_nxt = wdata_nxt;
    end
    we_nxt       = drive_phase && is_wr;
    set_rst_nxt  = drive_phase && (op_nxt == OP_SET);
    bsl_dac_nxt  = drive_phase && is_wr;
    wl_dac_nxt   = drive_phase || (state_nxt == ST_SENSE);
    read_dac_nxt = (drive_phase && is_rd) || (state_nxt == ST_SENSE);
    wl_en_nxt    = (state_nxt == ST_PULSE) || (state_nxt == ST_SENSE);
    bl_en_nxt    = ((state_nxt == ST_PULSE) && (is_rd || op_nxt == OP_SET))
                   || (state_nxt == ST_SENSE);
    sl_en_nxt    = (state_nxt == ST_PULSE) && (op_nxt == OP_RESET);
    sa_en_nxt    = (state_nxt == ST_SENSE);
    sa_clk_nxt   = (state_nxt == ST_SENSE) && (state != ST_SENSE);
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pw_q        <= '0;
      to_q        <= '0;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      cmd_ready   <= 1'b1;
      rram_busy   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= ERR_OK;
      rram_addr   <= '0;
      di          <= '0;
      we          <= 1'b0;
      set_rst     <= 1'b0;
      wl_dac_en   <= 1'b0;
      bsl_dac_en  <= 1'b0;
      read_dac_en <= 1'b0;
      wl_en       <= 1'b0;
      bl_en       <= 1'b0;
      sl_en       <= 1'b0;
      sa_en       <= 1'b0;
      sa_clk      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pw_q        <= pw_nxt;
      to_q        <= to_nxt;
      op_q        <= op_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      cmd_ready   <= (state_nxt == ST_IDLE);
      rram_busy   <= (state_nxt != ST_IDLE);
      rsp_valid   <= (state_nxt == ST_RESP);
      rsp_rdata   <= rdata_nxt;
      rsp_err     <= err_nxt;
      rram_addr   <= rram_addr_nxt;
      di          <= di_nxt;
      we          <= we_nxt;
      set_rst     <= set_rst_nxt;
      wl_dac_en   <= wl_dac_nxt;
      bsl_dac_en  <= bsl_dac_nxt;
      read_dac_en <= read_dac_nxt;
      wl_en       <= wl_en_nxt;
      bl_en       <= bl_en_nxt;
      sl_en       <= sl_en_nxt;
      sa_en       <= sa_en_nxt;
      sa_clk      <= sa_clk_nxt;
    end
  end

endmodule
